// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, instruction memory loaded by the
// debug unit, IF/ID pipeline register and a RUN/HALTED state machine that
// stops fetching when a HALT opcode reaches the decode stage.
module instruction_fetch #(
  parameter int         MEM_DEPTH   = 256,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_stall,
  input  logic                         i_halt,
  input  logic                         i_jump,
  input  logic [31:0]                  i_jump_addr,
  input  logic                         i_flush,
  input  logic                         i_load_enable,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_load_addr,
  input  logic [31:0]                  i_load_data,
  output logic [31:0]                  o_instruction,
  output logic [31:0]                  o_pc,
  output logic                         o_halted
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Instruction memory; read is combinational from the PC so the fetched
  // word lands in the IF/ID register on the same edge the PC advances.
  logic [31:0] mem [MEM_DEPTH];

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc_out_reg, pc_out_next;

  logic [AW-1:0] fetch_index;
  logic [31:0]   fetch_word;
  logic [31:0]   pc_plus4;
  logic          fetch_is_halt;

  // Word index drops the byte offset; upper PC bits alias, giving index wrap.
  assign fetch_index   = pc_reg[AW+1:2];
  assign fetch_word    = mem[fetch_index];
  assign pc_plus4      = pc_reg + 32'd4;
  assign fetch_is_halt = (fetch_word[31:26] == HALT_OPCODE);

  // Debug-unit loads are accepted in every state, even during reset.
  always_ff @(posedge i_clk) begin
    if (i_load_enable) begin
      mem[i_load_addr] <= i_load_data;
    end
  end

  // Next-state and next-register logic: jump > stall/halt > normal fetch.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    pc_out_next = pc_out_reg;

    case (state_reg)
      ST_RUN: begin
        if (i_jump) begin
          // Redirect: the wrong-path word is replaced by a NOP.
          pc_next    = i_jump_addr;
          instr_next = 32'h0;
        end else if (i_stall || i_halt) begin
          // Everything holds, but a flush still kills the held instruction.
          if (i_flush) begin
            instr_next = 32'h0;
          end
        end else begin
          pc_out_next = pc_plus4;
          if (i_flush) begin
            // A flushed HALT word is discarded and does not stop the machine.
            instr_next = 32'h0;
            pc_next    = pc_plus4;
          end else begin
            instr_next = fetch_word;
            if (fetch_is_halt) begin
              // PC stays on the HALT word; only reset leaves HALTED.
              state_next = ST_HALTED;
            end else begin
              pc_next = pc_plus4;
            end
          end
        end
      end
      ST_HALTED: begin
        // Feed NOPs so the downstream pipeline drains; all controls ignored.
        instr_next = 32'h0;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg  <= ST_RUN;
      pc_reg     <= 32'h0;
      instr_reg  <= 32'h0;
      pc_out_reg <= 32'h0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      pc_out_reg <= pc_out_next;
    end
  end

  assign o_instruction = instr_reg;
  assign o_pc          = pc_out_reg;
  assign o_halted      = (state_reg == ST_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// random stimulus, all compared against a behavioural model of the stage.
module tb_instruction_fetch;

  localparam int MEM_DEPTH = 256;
  localparam int AW        = 8;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_stall;
  logic          i_halt;
  logic          i_jump;
  logic [31:0]   i_jump_addr;
  logic          i_flush;
  logic          i_load_enable;
  logic [AW-1:0] i_load_addr;
  logic [31:0]   i_load_data;
  logic [31:0]   o_instruction;
  logic [31:0]   o_pc;
  logic          o_halted;

  always #5 i_clk = ~i_clk;

  instruction_fetch #(
    .MEM_DEPTH  (MEM_DEPTH),
    .HALT_OPCODE(6'b111111)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_stall      (i_stall),
    .i_halt       (i_halt),
    .i_jump       (i_jump),
    .i_jump_addr  (i_jump_addr),
    .i_flush      (i_flush),
    .i_load_enable(i_load_enable),
    .i_load_addr  (i_load_addr),
    .i_load_data  (i_load_data),
    .o_instruction(o_instruction),
    .o_pc         (o_pc),
    .o_halted     (o_halted)
  );

  // Behavioural model state
  logic [31:0] ref_mem [MEM_DEPTH];
  logic [31:0] ref_pc;
  logic [31:0] ref_ins;
  logic [31:0] ref_pco;
  logic        ref_halted;

  int vectors     = 0;
  int miscompares = 0;

  task automatic set_idle();
    i_reset       = 1'b0;
    i_stall       = 1'b0;
    i_halt        = 1'b0;
    i_jump        = 1'b0;
    i_jump_addr   = 32'h0;
    i_flush       = 1'b0;
    i_load_enable = 1'b0;
    i_load_addr   = '0;
    i_load_data   = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one edge from the rules of the fetch stage.
  task automatic model_step();
    logic [31:0] word;
    word = ref_mem[(ref_pc >> 2) % MEM_DEPTH];
    if (i_reset) begin
      ref_pc     = 32'h0;
      ref_ins    = 32'h0;
      ref_pco    = 32'h0;
      ref_halted = 1'b0;
    end else if (ref_halted) begin
      ref_ins = 32'h0;
    end else if (i_jump) begin
      ref_pc  = i_jump_addr;
      ref_ins = 32'h0;
    end else if (i_stall || i_halt) begin
      if (i_flush) ref_ins = 32'h0;
    end else begin
      ref_pco = ref_pc + 32'd4;
      if (i_flush) begin
        ref_ins = 32'h0;
        ref_pc  = ref_pc + 32'd4;
      end else begin
        ref_ins = word;
        if ((word >> 26) == 32'd63) ref_halted = 1'b1;
        else ref_pc = ref_pc + 32'd4;
      end
    end
    if (i_load_enable) ref_mem[i_load_addr] = i_load_data;
  endtask

  // One clock: update model, take the edge, compare all outputs.
  task automatic tick(input string tag);
    model_step();
    @(posedge i_clk);
    #1;
    check({tag, "/ins"}, o_instruction, ref_ins);
    check({tag, "/pc"}, o_pc, ref_pco);
    check({tag, "/halted"}, {31'b0, o_halted}, {31'b0, ref_halted});
  endtask

  task automatic reset_with_load(input int addr, input logic [31:0] data);
    set_idle();
    i_reset       = 1'b1;
    i_load_enable = 1'b1;
    i_load_addr   = addr[AW-1:0];
    i_load_data   = data;
    tick("reset_load");
    set_idle();
  endtask

  initial begin
    logic [31:0] rnd;
    set_idle();
    ref_pc = 0; ref_ins = 0; ref_pco = 0; ref_halted = 0;

    // Fill the whole memory while reset is held; writes must land anyway.
    i_reset = 1'b1;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      i_load_enable = 1'b1;
      i_load_addr   = i[AW-1:0];
      if (i == 0) i_load_data = 32'h20010005;
      else if (i == 1) i_load_data = 32'h20020007;
      else if (i == 2) i_load_data = 32'hFC000000;
      else i_load_data = $urandom() & 32'h7FFF_FFFF;
      tick("load_in_reset");
    end
    check("reset_ins", o_instruction, 32'h0);
    check("reset_pc", o_pc, 32'h0);

    // Program runs three words and halts on the third.
    set_idle();
    tick("run0");
    check("w0_ins", o_instruction, 32'h20010005);
    check("w0_pc", o_pc, 32'd4);
    tick("run1");
    check("w1_ins", o_instruction, 32'h20020007);
    check("w1_pc", o_pc, 32'd8);
    tick("run2");
    check("w2_ins", o_instruction, 32'hFC000000);
    check("w2_pc", o_pc, 32'd12);
    check("w2_halted", {31'b0, o_halted}, 32'd1);
    // Controls toggled while halted must all be ignored.
    for (int i = 0; i < 6; i++) begin
      i_jump = i[0]; i_jump_addr = 32'h80; i_stall = i[1]; i_flush = i[2];
      tick("halted_ignore");
    end
    check("halted_drain", o_instruction, 32'h0);
    check("halted_pc_hold", o_pc, 32'd12);

    // Reset out of HALTED; memory survives and refetch of word 0 matches.
    set_idle();
    i_reset = 1'b1;
    tick("reset_from_halt");
    check("rst_halt_flag", {31'b0, o_halted}, 32'd0);
    set_idle();
    tick("refetch0");
    check("refetch_w0", o_instruction, 32'h20010005);

    // Stall for two cycles at PC=8; no lost or duplicated word.
    reset_with_load(2, 32'h20030009);
    tick("s_f0");
    tick("s_f1");
    i_stall = 1'b1;
    tick("stall0");
    tick("stall1");
    check("stall_ins", o_instruction, 32'h20020007);
    check("stall_pc", o_pc, 32'd8);
    set_idle();
    tick("resume");
    check("resume_ins", o_instruction, 32'h20030009);
    check("resume_pc", o_pc, 32'd12);

    // Jump together with stall: jump wins.
    i_jump = 1'b1; i_jump_addr = 32'h40; i_stall = 1'b1;
    tick("jump_stall");
    check("jump_nop", o_instruction, 32'h0);
    check("jump_pc_hold", o_pc, 32'd12);
    set_idle();
    tick("jump_target");
    check("target_ins", o_instruction, ref_mem[16]);
    check("target_pc", o_pc, 32'h44);

    // Flushed HALT word at PC=4 must not halt.
    reset_with_load(1, 32'hFC000000);
    tick("f_f0");
    i_flush = 1'b1;
    tick("flush_halt");
    check("flush_ins", o_instruction, 32'h0);
    check("flush_halted", {31'b0, o_halted}, 32'd0);
    set_idle();
    tick("after_flush");
    check("after_flush_pc", o_pc, 32'd12);
    check("after_flush_ins", o_instruction, 32'h20030009);
    reset_with_load(1, 32'h20020007);

    // Index wrap: 0x3FC fetches word 255, then 0x400 fetches word 0.
    i_jump = 1'b1; i_jump_addr = 32'h3FC;
    tick("jump_3fc");
    set_idle();
    tick("fetch_3fc");
    check("wrap_w255", o_instruction, ref_mem[255]);
    check("wrap_pc400", o_pc, 32'h400);
    tick("fetch_400");
    check("wrap_w0", o_instruction, 32'h20010005);
    check("wrap_pc404", o_pc, 32'h404);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      i_reset       = ($urandom_range(99) < 2);
      i_jump        = ($urandom_range(99) < 10);
      rnd           = $urandom();
      i_jump_addr   = rnd[0] ? rnd : (rnd & 32'h0000_03FF);
      i_stall       = ($urandom_range(99) < 15);
      i_halt        = ($urandom_range(99) < 5);
      i_flush       = ($urandom_range(99) < 10);
      i_load_enable = ($urandom_range(99) < 8);
      i_load_addr   = AW'($urandom_range(MEM_DEPTH - 1));
      rnd           = $urandom();
      i_load_data   = ($urandom_range(15) == 0) ? (rnd | 32'hFC00_0000) : (rnd & 32'h7FFF_FFFF);
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: i_clk and i_reset.
REQ-002 Parameter MEM_DEPTH, default 256, instruction memory depth in 32-bit words (power of 2).
REQ-003 Parameter HALT_OPCODE, default 6'b111111, opcode field value that identifies a HALT instruction.
REQ-004 i_clk  input  1  rising-edge clock.
REQ-005 i_reset  input  1  synchronous active-high reset.
REQ-006 i_stall  input  1  hazard-unit stall; holds PC and IF/ID outputs.
REQ-007 i_halt  input  1  external pause from the debug unit; holds PC and outputs while high.
REQ-008 i_jump  input  1  redirect request from ID (branch taken / jump).
REQ-009 i_jump_addr  input  32  byte address of the redirect target.
REQ-010 i_flush  input  1  replace the IF/ID instruction with NOP.
REQ-011 i_load_enable  input  1  instruction-memory write strobe from the debug unit.
REQ-012 i_load_addr  input  log2(MEM_DEPTH)  word index to write.
REQ-013 i_load_data  input  32  instruction word to write.
REQ-014 o_instruction  output  32  IF/ID instruction register, feeds ID i_instruction.
REQ-015 o_pc  output  32  IF/ID register holding fetched PC+4, feeds ID i_pc.
REQ-016 o_halted  output  1  high while in the HALTED state.

Function
REQ-017 The block SHALL keep a 32-bit byte-address PC; memory word index = PC[log2(MEM_DEPTH)+1:2]; PC[1:0] ignored.
REQ-018 Memory read SHALL be combinational from PC; the fetched word SHALL appear on o_instruction one cycle after PC holds its address (latency 1).
REQ-019 Memory write SHALL be synchronous: when i_load_enable=1, mem[i_load_addr] <= i_load_data at the clock edge, in any state, independent of stall/halt/jump.
REQ-020 The state machine SHALL have two states: RUN and HALTED; reset enters RUN.
REQ-021 In RUN, per edge, priority (highest first): i_jump; then (i_stall or i_halt); then normal fetch.
REQ-022 i_jump=1: PC <= i_jump_addr; o_instruction <= 32'h0 (NOP); o_pc <= o_pc (unchanged); i_jump overrides i_stall and i_halt.
REQ-023 i_stall=1 or i_halt=1 (no jump): PC, o_instruction and o_pc SHALL hold; i_flush=1 in the same cycle SHALL still force o_instruction <= 32'h0.
REQ-024 Normal fetch: o_instruction <= mem[index(PC)]; o_pc <= PC+4; PC <= PC+4, or o_instruction <= 32'h0 instead if i_flush=1.
REQ-025 PC+4 SHALL wrap modulo 2^32; the memory index SHALL wrap modulo MEM_DEPTH.
REQ-026 When the fetched word has [31:26]=HALT_OPCODE during a normal fetch (no flush), the word SHALL be passed to o_instruction, PC SHALL not advance, and the state SHALL become HALTED on that edge.
REQ-027 A HALT word discarded by i_jump or i_flush SHALL NOT cause the HALTED transition.
REQ-028 In HALTED: PC frozen; o_instruction <= 32'h0 every cycle (pipeline drains); o_pc holds; i_jump, i_stall, i_halt, i_flush ignored; exit only via i_reset.
REQ-029 o_halted SHALL be 1 exactly in the cycles the state register is HALTED.

Reset
REQ-030 On i_reset=1 at an edge: PC <= 0, o_instruction <= 0, o_pc <= 0, state <= RUN, o_halted <= 0; reset SHALL override every other input, including mid-stall, mid-jump and HALTED.
REQ-031 Reset SHALL NOT clear instruction memory; a simultaneous i_load_enable write SHALL still take effect.

Verification
REQ-032 Load mem[0..2] = 0x20010005, 0x20020007, 0xFC000000, release reset -> o_instruction 0x20010005/0x20020007/0xFC000000 with o_pc 4/8/12 on consecutive cycles, then o_halted=1 and o_instruction=0.
REQ-033 Running sequence, i_stall=1 for 2 cycles at PC=8 -> o_instruction/o_pc unchanged for 2 cycles; fetch resumes at PC=8 with no lost or duplicated word.
REQ-034 i_jump=1, i_jump_addr=0x40 together with i_stall=1 -> next o_instruction=0, following cycle o_instruction=mem[16], o_pc=0x44.
REQ-035 HALT word at PC=4 with i_flush=1 on that fetch -> o_instruction=0, o_halted stays 0, PC advances to 8.
REQ-036 In HALTED, assert i_reset for 1 cycle -> PC=0, o_halted=0, o_instruction=0, memory contents intact (re-fetch of mem[0] matches load).
REQ-037 PC driven to 0x3FC with MEM_DEPTH=256 -> fetches mem[255], then PC=0x400 fetches mem[0] (index wrap).
